rv32i_control_fsm: RTL
======================

Name: rv32i_control_fsm

Overview:
Multicycle control unit for the CP1 RV32I datapath. Decodes the latched instruction fields and sequences fetch, decode, execute, memory and writeback states. Drives every datapath mux select (pcmux, marmux, cmpmux, alumux1/2, regfilemux package types), register load enables and the memory read/write handshake. Sits directly upstream of all datapath muxes.

Parameters:
WAIT_LIMIT, 0, max cycles spent waiting for mem_resp before mem_timeout pulses; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
br_en  in  1  comparator result
mar_low  in  2  MAR[1:0]
mem_resp  in  1  memory access complete
load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out  out  1 each  register enables
pcmux_sel  out  2  pcmux_sel_t
marmux_sel  out  1  marmux_sel_t
cmpmux_sel  out  1  cmpmux_sel_t
alumux1_sel  out  1  alumux1_sel_t
alumux2_sel  out  3  alumux2_sel_t
regfilemux_sel  out  4  regfilemux_sel_t
aluop  out  3  add=0 sll=1 sra=2 sub=3 xor=4 srl=5 or=6 and=7
cmpop  out  3  branch funct3 encoding
mem_read, mem_write  out  1  memory request
mem_byte_enable  out  4  write strobes
mem_timeout  out  1  one-cycle pulse when the watchdog expires

Behaviour:
- Reset (async, any state): state<=FETCH1, wait counter<=0. Outputs are Moore-decoded from state plus fields, so FETCH1 outputs hold during and after reset: load_mar=1, marmux_sel=pc_out, all other enables, mem_read/mem_write and mem_timeout 0. Default selects are 0, mem_byte_enable=4'b1111.
- States: FETCH1 -> FETCH2 -> FETCH3 -> DECODE -> {IMM, LUI, AUIPC, BR, JAL, JALR, REG, CALC_ADDR} -> (loads) LD1 -> LD2, (stores) ST1 -> ST2 -> FETCH1.
- FETCH2: mem_read=1, load_mdr=1. Stays in FETCH2 until mem_resp=1. FETCH3: load_ir=1. DECODE: no enables.
- Illegal opcode in DECODE: go to FETCH1 with no architectural update.
- IMM: alumux1=rs1_out, alumux2=i_imm, aluop=funct3 mapping. funct3=001 selects sll. funct3=101 selects sra if funct7[5] else srl. slti/sltiu: cmpmux=i_imm, cmpop=blt/bltu, regfilemux=br_en. load_regfile=1, load_pc=1 (pc_plus4). Then FETCH1.
- REG: same as IMM with alumux2=rs2_out and cmpmux=rs2_out. funct3=000 with funct7[5]=1 selects sub. slt/sltu use regfilemux=br_en.
- LUI: regfilemux=u_imm. AUIPC: alumux1=pc_out, alumux2=u_imm, add. Both load regfile and pc.
- BR: cmpop=funct3, cmpmux=rs2_out, alumux1=pc_out, alumux2=b_imm, add, load_pc=1. pcmux=alu_out if br_en else pc_plus4.
- JAL: regfilemux=pc_plus4, pcmux=alu_out, alumux1=pc_out, alumux2=j_imm.
- JALR: pcmux=alu_mod2, alumux1=rs1_out, alumux2=i_imm. regfile written with pc_plus4 in the same cycle.
- CALC_ADDR: add with alumux2 = i_imm (load) or s_imm (store), load_mar=1, marmux=alu_out. Stores also set load_data_out=1.
- LD1: mem_read=1, load_mdr=1, holds until mem_resp. LD2: load_regfile=1, load_pc=1. regfilemux = lb/lh/lw/lbu/lhu from funct3 000/001/010/100/101.
- ST1: mem_write=1, holds until mem_resp. Byte enables: sb 4'b0001<<mar_low; sh 4'b0011<<mar_low (mar_low[1] only); sw 4'b1111. ST2: load_pc=1.
- Watchdog: counter increments each cycle in FETCH2/LD1/ST1 while mem_resp=0 and clears on state exit. If WAIT_LIMIT!=0 and the count reaches WAIT_LIMIT: mem_timeout pulses 1 cycle, counter clears, state is held (request stays asserted).
- mem_resp arriving in any non-wait state is ignored.

Test Plan:
- Reset then fetch: rst 1->0, mem_resp on 3rd FETCH2 cycle -> FETCH1(load_mar) -> FETCH2 x3 -> FETCH3 load_ir=1 -> DECODE.
- addi (opcode 0010011, funct3 000) -> IMM: aluop=0, alumux2=0, regfilemux=0, load_regfile=load_pc=1.
- beq with br_en=1 then br_en=0 -> pcmux_sel=1 then 0; load_regfile=0 both times.
- sb with mar_low=2'b11 -> ST1 mem_byte_enable=4'b1000, mem_write held 4 cycles until mem_resp.
- lhu (funct3 101) -> LD2 regfilemux_sel=8; jalr -> pcmux_sel=2, regfilemux_sel=4.
- WAIT_LIMIT=4, mem_resp never asserted in FETCH2 -> mem_timeout pulses every 4th cycle. Assert rst mid-LD1 -> state FETCH1 and mem_read=0 immediately (asynchronous).

Source files
------------

// File: rtl/rv32i_control_fsm.sv
// Multicycle control FSM for the RV32I datapath: it sequences fetch, decode,
// execute, memory and writeback, and drives every datapath mux select and load enable.
module rv32i_control_fsm #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_en,
  input  logic [1:0] mar_low,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_data_out,
  output logic [1:0] pcmux_sel,
  output logic       marmux_sel,
  output logic       cmpmux_sel,
  output logic       alumux1_sel,
  output logic [2:0] alumux2_sel,
  output logic [3:0] regfilemux_sel,
  output logic [2:0] aluop,
  output logic [2:0] cmpop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] mem_byte_enable,
  output logic       mem_timeout
);

  localparam logic [3:0] S_FETCH1    = 4'd0;
  localparam logic [3:0] S_FETCH2    = 4'd1;
  localparam logic [3:0] S_FETCH3    = 4'd2;
  localparam logic [3:0] S_DECODE    = 4'd3;
  localparam logic [3:0] S_IMM       = 4'd4;
  localparam logic [3:0] S_LUI       = 4'd5;
  localparam logic [3:0] S_AUIPC     = 4'd6;
  localparam logic [3:0] S_BR        = 4'd7;
  localparam logic [3:0] S_JAL       = 4'd8;
  localparam logic [3:0] S_JALR      = 4'd9;
  localparam logic [3:0] S_REG       = 4'd10;
  localparam logic [3:0] S_CALC_ADDR = 4'd11;
  localparam logic [3:0] S_LD1       = 4'd12;
  localparam logic [3:0] S_LD2       = 4'd13;
  localparam logic [3:0] S_ST1       = 4'd14;
  localparam logic [3:0] S_ST2       = 4'd15;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [1:0] PCMUX_PC_PLUS4 = 2'd0;
  localparam logic [1:0] PCMUX_ALU_OUT  = 2'd1;
  localparam logic [1:0] PCMUX_ALU_MOD2 = 2'd2;

  localparam logic MARMUX_PC_OUT  = 1'b0;
  localparam logic MARMUX_ALU_OUT = 1'b1;
  localparam logic CMPMUX_RS2_OUT = 1'b0;
  localparam logic CMPMUX_I_IMM   = 1'b1;
  localparam logic ALUMUX1_RS1    = 1'b0;
  localparam logic ALUMUX1_PC     = 1'b1;

  localparam logic [2:0] ALUMUX2_I_IMM   = 3'd0;
  localparam logic [2:0] ALUMUX2_U_IMM   = 3'd1;
  localparam logic [2:0] ALUMUX2_B_IMM   = 3'd2;
  localparam logic [2:0] ALUMUX2_S_IMM   = 3'd3;
  localparam logic [2:0] ALUMUX2_J_IMM   = 3'd4;
  localparam logic [2:0] ALUMUX2_RS2_OUT = 3'd5;

  localparam logic [3:0] RF_ALU_OUT  = 4'd0;
  localparam logic [3:0] RF_BR_EN    = 4'd1;
  localparam logic [3:0] RF_U_IMM    = 4'd2;
  localparam logic [3:0] RF_LW       = 4'd3;
  localparam logic [3:0] RF_PC_PLUS4 = 4'd4;
  localparam logic [3:0] RF_LB       = 4'd5;
  localparam logic [3:0] RF_LBU      = 4'd6;
  localparam logic [3:0] RF_LH       = 4'd7;
  localparam logic [3:0] RF_LHU      = 4'd8;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SRA = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_SRL = 3'd5;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] CMP_BLT  = 3'b100;
  localparam logic [2:0] CMP_BLTU = 3'b110;

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_LIMIT - 1);

  logic [3:0]    state_r;
  logic [3:0]    next_state_s;
  logic [CW-1:0] wait_cnt_r;
  logic          mem_timeout_r;
  logic          waiting_s;
  logic          timeout_hit_s;
  logic          unused_funct7_s;

  // Only funct7[5] distinguishes sub/sra; the remaining bits are don't-care.
  assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

  function automatic logic [3:0] decode_f(input logic [6:0] op);
    logic [3:0] ns;
    case (op)
      OP_IMM:   ns = S_IMM;
      OP_REG:   ns = S_REG;
      OP_LUI:   ns = S_LUI;
      OP_AUIPC: ns = S_AUIPC;
      OP_BR:    ns = S_BR;
      OP_JAL:   ns = S_JAL;
      OP_JALR:  ns = S_JALR;
      OP_LOAD:  ns = S_CALC_ADDR;
      OP_STORE: ns = S_CALC_ADDR;
      default:  ns = S_FETCH1;
    endcase
    return ns;
  endfunction

  function automatic logic [2:0] alu_op_f(input logic [2:0] f3, input logic f7_5,
                                          input logic is_reg);
    logic [2:0] op;
    case (f3)
      F3_SR:   op = f7_5 ? ALU_SRA : ALU_SRL;
      F3_ADD:  op = (is_reg && f7_5) ? ALU_SUB : ALU_ADD;
      default: op = f3;
    endcase
    return op;
  endfunction

  function automatic logic [3:0] load_mux_f(input logic [2:0] f3);
    logic [3:0] sel;
    case (f3)
      3'b000:  sel = RF_LB;
      3'b001:  sel = RF_LH;
      3'b100:  sel = RF_LBU;
      3'b101:  sel = RF_LHU;
      default: sel = RF_LW;
    endcase
    return sel;
  endfunction

  function automatic logic [3:0] store_be_f(input logic [2:0] f3, input logic [1:0] low);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << low;
      3'b001:  be = 4'b0011 << {low[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH1;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; wait states advance only on mem_resp, so a timeout holds them.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH1:    next_state_s = S_FETCH2;
      S_FETCH2:    next_state_s = mem_resp ? S_FETCH3 : S_FETCH2;
      S_FETCH3:    next_state_s = S_DECODE;
      S_DECODE:    next_state_s = decode_f(opcode);
      S_CALC_ADDR: next_state_s = (opcode == OP_STORE) ? S_ST1 : S_LD1;
      S_LD1:       next_state_s = mem_resp ? S_LD2 : S_LD1;
      S_ST1:       next_state_s = mem_resp ? S_ST2 : S_ST1;
      S_IMM, S_LUI, S_AUIPC, S_BR, S_JAL, S_JALR, S_REG, S_LD2, S_ST2:
                   next_state_s = S_FETCH1;
      default:     next_state_s = S_FETCH1;
    endcase
  end

  assign waiting_s     = (state_r == S_FETCH2) || (state_r == S_LD1) || (state_r == S_ST1);
  assign timeout_hit_s = (WAIT_LIMIT != 0) && waiting_s && !mem_resp && (wait_cnt_r == LAST_CNT);

  // Memory-wait watchdog counter and its one-cycle timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r    <= '0;
      mem_timeout_r <= 1'b0;
    end else begin
      mem_timeout_r <= timeout_hit_s;
      if (!waiting_s || mem_resp || timeout_hit_s) begin
        wait_cnt_r <= '0;
      end else begin
        wait_cnt_r <= wait_cnt_r + CW'(1);
      end
    end
  end

  assign mem_timeout = mem_timeout_r;

  // Moore output decode from the current state and the latched instruction fields.
  always_comb begin
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_data_out   = 1'b0;
    pcmux_sel       = PCMUX_PC_PLUS4;
    marmux_sel      = MARMUX_PC_OUT;
    cmpmux_sel      = CMPMUX_RS2_OUT;
    alumux1_sel     = ALUMUX1_RS1;
    alumux2_sel     = ALUMUX2_I_IMM;
    regfilemux_sel  = RF_ALU_OUT;
    aluop           = ALU_ADD;
    cmpop           = 3'b000;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'b1111;
    case (state_r)
      S_FETCH1: begin
        load_mar   = 1'b1;
        marmux_sel = MARMUX_PC_OUT;
      end
      S_FETCH2, S_LD1: begin
        mem_read = 1'b1;
        load_mdr = 1'b1;
      end
      S_FETCH3: load_ir = 1'b1;
      S_DECODE: begin
      end
      S_IMM, S_REG: begin
        load_regfile = 1'b1;
        load_pc      = 1'b1;
        alumux2_sel  = (state_r == S_REG) ? ALUMUX2_RS2_OUT : ALUMUX2_I_IMM;
        aluop        = alu_op_f(funct3, funct7[5], state_r == S_REG);
        if ((funct3 == F3_SLT) || (funct3 == F3_SLTU)) begin
          cmpmux_sel     = (state_r == S_REG) ? CMPMUX_RS2_OUT : CMPMUX_I_IMM;
          cmpop          = (funct3 == F3_SLT) ? CMP_BLT : CMP_BLTU;
          regfilemux_sel = RF_BR_EN;
        end else begin
          regfilemux_sel = RF_ALU_OUT;
        end
      end
      S_LUI: begin
        load_regfile   = 1'b1;
        load_pc        = 1'b1;
        regfilemux_sel = RF_U_IMM;
      end
      S_AUIPC: begin
        load_regfile = 1'b1;
        load_pc      = 1'b1;
        alumux1_sel  = ALUMUX1_PC;
        alumux2_sel  = ALUMUX2_U_IMM;
      end
      S_BR: begin
        load_pc     = 1'b1;
        cmpop       = funct3;
        alumux1_sel = ALUMUX1_PC;
        alumux2_sel = ALUMUX2_B_IMM;
        pcmux_sel   = br_en ? PCMUX_ALU_OUT : PCMUX_PC_PLUS4;
      end
      S_JAL: begin
        load_regfile   = 1'b1;
        load_pc        = 1'b1;
        regfilemux_sel = RF_PC_PLUS4;
        pcmux_sel      = PCMUX_ALU_OUT;
        alumux1_sel    = ALUMUX1_PC;
        alumux2_sel    = ALUMUX2_J_IMM;
      end
      S_JALR: begin
        load_regfile   = 1'b1;
        load_pc        = 1'b1;
        regfilemux_sel = RF_PC_PLUS4;
        pcmux_sel      = PCMUX_ALU_MOD2;
      end
      S_CALC_ADDR: begin
        load_mar   = 1'b1;
        marmux_sel = MARMUX_ALU_OUT;
        if (opcode == OP_STORE) begin
          alumux2_sel   = ALUMUX2_S_IMM;
          load_data_out = 1'b1;
        end else begin
          alumux2_sel = ALUMUX2_I_IMM;
        end
      end
      S_LD2: begin
        load_regfile   = 1'b1;
        load_pc        = 1'b1;
        regfilemux_sel = load_mux_f(funct3);
      end
      S_ST1: begin
        mem_write       = 1'b1;
        mem_byte_enable = store_be_f(funct3, mar_low);
      end
      S_ST2:   load_pc = 1'b1;
      default: load_mar = 1'b1;
    endcase
  end

endmodule
